// File: rtl/serial_xfer_ctrl.sv
// Command sequencer for a shift-register pair: parallel load,
// counted shift, abort, and a one-cycle completion pulse.
module serial_xfer_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic             abort,
    output logic             load,
    output logic             shift_ctl,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] remaining
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_rem;
    logic [CNT_W-1:0] w_rem_nxt;
    logic             r_aborted;
    logic             w_ab_nxt;
    logic             w_accept;
    logic [CNT_W-1:0] w_eff_cnt;

    assign cmd_ready = rstn && (r_state == S_IDLE);
    assign w_accept  = cmd_valid && (r_state == S_IDLE);
    assign w_eff_cnt = (cmd_cnt == '0) ? CNT_W'(WIDTH) : cmd_cnt;
    assign aborted   = r_aborted;
    assign remaining = r_rem;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_rem     <= '0;
            r_aborted <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_rem     <= w_rem_nxt;
            r_aborted <= w_ab_nxt;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_rem_nxt = r_rem;
        w_ab_nxt  = 1'b0;
        load      = 1'b0;
        shift_ctl = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                busy      = 1'b0;
                w_rem_nxt = '0;
                if (w_accept) begin
                    unique case (cmd_op)
                        2'b00: w_next = S_DONE;
                        2'b01: w_next = S_LOAD;
                        2'b10: begin
                            w_next    = S_SHIFT;
                            w_rem_nxt = w_eff_cnt;
                        end
                        2'b11: begin
                            w_next    = S_LOAD;
                            w_rem_nxt = w_eff_cnt;
                        end
                        default: w_next = S_IDLE;
                    endcase
                end
            end
            S_LOAD: begin
                load = 1'b1;
                if (abort) begin
                    w_next    = S_DONE;
                    w_rem_nxt = '0;
                    w_ab_nxt  = 1'b1;
                // a plain LOAD carries a zero count, LOAD_SHIFT never does
                end else if (r_rem == '0) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shift_ctl = 1'b1;
                w_rem_nxt = r_rem - CNT_W'(1);
                if (abort) begin
                    w_next    = S_DONE;
                    w_rem_nxt = '0;
                    w_ab_nxt  = 1'b1;
                end else if (r_rem == CNT_W'(1)) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done     = 1'b1;
                w_ab_nxt = r_aborted;
                w_next   = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (r_state == S_DONE) w_ab_nxt = 1'b0;
    end

endmodule
